dmem_ctrl: RTL
==============

Name: dmem_ctrl

Overview:
- Parametrised successor of the datapath's data memory: 32-bit word array with byte, halfword and word access.
- Loads are sign- or zero-extended; stores are byte-lane merged.
- Access uses a valid/ready request with programmable wait states and a one-cycle response pulse.
- Misaligned accesses are detected; reset clears the array with a hardware sweep. Sits in the MEM stage; req_ready low stalls the pipeline.

Parameters:
- DEPTH, 256, number of 32-bit words; power of two, 2..4096.
- ADDR_W, 32, byte-address width.
- WAIT_STATES, 1, extra cycles per access; 0..7.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  controller accepts a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  formatted load data; 0 for stores and errors.
- misalign  out  1  pulses with rsp_valid on an alignment or size error.
- init_done  out  1  array cleared and ready.

Behaviour:
- Reset state: state=CLEAR, clr_idx=0, req_ready=0, rsp_valid=0, rsp_rdata=0, misalign=0, init_done=0.
- Reset mid-operation: any pending access is abandoned with no write; the sweep restarts.
- Memory layout:
  - Word index = req_addr[log2(DEPTH)+1:2]; upper bits are ignored, so addresses alias/wrap.
  - Little-endian: byte lane addr[1:0]=0 is bits 7:0.
- State CLEAR:
  - Writes 0 to word clr_idx each cycle, then increments clr_idx.
  - After word DEPTH-1 is written: state goes to IDLE and init_done goes to 1 on the same edge.
  - init_done rises DEPTH cycles after the first non-reset edge.
  - req_ready=0 throughout; requests are ignored, not queued.
- State IDLE:
  - req_ready=1.
  - Handshake on req_valid&&req_ready: latch we/size/unsigned/addr/wdata, load wait counter = WAIT_STATES, go to BUSY.
- State BUSY:
  - req_ready=0.
  - Counter decrements each cycle while nonzero.
  - On the edge where counter==0: commit the access, assert rsp_valid for 1 cycle, return to IDLE.
- Timing:
  - Latency: accept at edge k, rsp_valid high in the cycle after edge k+1+WAIT_STATES.
  - req_ready is high again in that same cycle.
  - Throughput: one access per 2+WAIT_STATES cycles.
- Alignment check (evaluated on latched request):
  - Half requires addr[0]=0; word requires addr[1:0]=0; size 11 is always an error.
  - On error: no write, rsp_rdata=0, misalign=1 with the rsp_valid pulse.
- Stores:
  - byte replaces the lane addr[1:0] with wdata[7:0].
  - half replaces lanes {addr[1],1},{addr[1],0} with wdata[15:0].
  - word replaces all lanes.
  - rsp_rdata=0.
- Loads:
  - Extract the lane(s), then extend per req_unsigned.
  - Word loads ignore req_unsigned.
  - A load reads the array contents as of the commit edge.
- Output holding:
  - rsp_rdata holds its value until the next response.
  - misalign is 0 except during an error pulse.
- Back-to-back requests to the same word: the second request observes the first store, since the commit precedes the next accept.

Decomposition:
- Package dmem_pkg:
  - SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILLEGAL encodings.
  - State enum {CLEAR, IDLE, BUSY}.
  - Constant WAIT_W=3.
- Sub-module dmem_lane_fmt (combinational):
  - Inputs: size, unsigned, addr[1:0], old word, wdata.
  - Outputs: merged store word, formatted load data, misalign flag.
  - Top level holds the FSM, counters, array and output registers.

Test Plan:
- Reset, DEPTH=256 → init_done rises exactly 256 cycles after reset deasserts; lw 0x000000FC returns 0x00000000.
- WAIT_STATES=1, sw 0x00000010←0xDEADBEEF → rsp_valid exactly 2 cycles after accept; then lw 0x10 → 0xDEADBEEF. Throughout BUSY, req_ready=0 and a held req_valid is not accepted.
- After the above:
  - lb 0x13 → 0xFFFFFFDE; lbu 0x13 → 0x000000DE.
  - lh 0x12 → 0xFFFFDEAD; lhu 0x10 → 0x0000BEEF.
  - sb 0x11←0x11 then lw 0x10 → 0xDEAD11EF.
- Misaligned:
  - lw 0x12 → misalign pulse, rsp_rdata 0.
  - sh 0x13←0xFFFF → misalign, word 0x10 unchanged.
  - req_size=11 at 0x10 → misalign.
- Wrap, DEPTH=256: sw 0x00000400←0x12345678, then lw 0x00000000 → 0x12345678.
- Reset mid-operation: assert reset during BUSY of sw 0x20←0xCAFEF00D → no rsp_valid; after init_done, lw 0x20 → 0x00000000.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory controller: access sizes, FSM states
// and the wait-state counter width.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    localparam int WAIT_W = 3;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        BUSY  = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_lane_fmt.sv
// Combinational byte-lane logic: store merge into the old word, load
// extraction with sign/zero extension, and alignment/size error detection.
module dmem_lane_fmt
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        zero_ext,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] merged,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = old_word[{addr_lo, 3'b000} +: 8];
        sel_half = addr_lo[1] ? old_word[31:16] : old_word[15:0];

        merged = old_word;
        case (size)
            SZ_BYTE: merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            SZ_HALF: begin
                if (addr_lo[1]) merged[31:16] = wdata[15:0];
                else            merged[15:0]  = wdata[15:0];
            end
            SZ_WORD: merged = wdata;
            default: merged = old_word;
        endcase

        load_data = '0;
        case (size)
            SZ_BYTE: load_data = zero_ext ? {24'b0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
            SZ_HALF: load_data = zero_ext ? {16'b0, sel_half} : {{16{sel_half[15]}}, sel_half};
            SZ_WORD: load_data = old_word;
            default: load_data = '0;
        endcase

        misalign = (size == SZ_ILLEGAL)
                || (size == SZ_HALF && addr_lo[0])
                || (size == SZ_WORD && addr_lo != 2'b00);
    end

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data memory: word array with byte/half/word access, programmable
// wait states, one-cycle response pulse and a clearing sweep after reset.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              misalign,
    output logic              init_done
);

    localparam int IDX_W = $clog2(DEPTH);

    state_t             state;
    logic [IDX_W-1:0]   clr_idx;
    logic [WAIT_W-1:0]  wait_cnt;

    logic               lat_we;
    logic [1:0]         lat_size;
    logic               lat_zext;
    logic [IDX_W+1:0]   lat_addr;
    logic [31:0]        lat_wdata;

    logic [31:0]        mem [DEPTH];
    logic [31:0]        old_word;
    logic [31:0]        merged;
    logic [31:0]        load_data;
    logic               fmt_err;
    logic               commit;
    logic               mem_we;
    logic [IDX_W-1:0]   mem_idx;
    logic [31:0]        mem_wdata;

    // Address bits above the array are deliberately ignored so accesses alias.
    generate
        if (ADDR_W > IDX_W + 2) begin : g_alias
            logic unused_addr_hi;
            assign unused_addr_hi = ^req_addr[ADDR_W-1:IDX_W+2];
        end
    endgenerate

    assign req_ready = (state == IDLE);
    assign old_word  = mem[lat_addr[IDX_W+1:2]];
    assign commit    = (state == BUSY) && (wait_cnt == '0);

    dmem_lane_fmt u_fmt (
        .size      (lat_size),
        .zero_ext  (lat_zext),
        .addr_lo   (lat_addr[1:0]),
        .old_word  (old_word),
        .wdata     (lat_wdata),
        .merged    (merged),
        .load_data (load_data),
        .misalign  (fmt_err)
    );

    // Single write port shared by the clearing sweep and store commits.
    always_comb begin
        mem_we    = 1'b0;
        mem_idx   = lat_addr[IDX_W+1:2];
        mem_wdata = merged;
        if (!reset) begin
            if (state == CLEAR) begin
                mem_we    = 1'b1;
                mem_idx   = clr_idx;
                mem_wdata = '0;
            end else if (commit && lat_we && !fmt_err) begin
                mem_we    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_idx] <= mem_wdata;
    end

    always_ff @(posedge clk) begin
        if (req_valid && req_ready) begin
            lat_we    <= req_we;
            lat_size  <= req_size;
            lat_zext  <= req_unsigned;
            lat_addr  <= req_addr[IDX_W+1:0];
            lat_wdata <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= CLEAR;
            clr_idx   <= '0;
            wait_cnt  <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            misalign  <= 1'b0;
            init_done <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            misalign  <= 1'b0;
            case (state)
                CLEAR: begin
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == IDX_W'(DEPTH - 1)) begin
                        state     <= IDLE;
                        init_done <= 1'b1;
                    end
                end
                IDLE: begin
                    if (req_valid) begin
                        wait_cnt <= WAIT_W'(WAIT_STATES);
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end else begin
                        rsp_valid <= 1'b1;
                        misalign  <= fmt_err;
                        rsp_rdata <= (lat_we || fmt_err) ? '0 : load_data;
                        state     <= IDLE;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule
